fp_compare_pipe: RTL and testbench

Parametrised, pipelined floating-point compare unit for the CPU FPU. It accepts operand pairs under a valid/ready handshake and returns, two cycles later, a 2-bit relation code, a boolean result for the requested predicate, a min/max selection, and an invalid-operation flag. Compared with the combinational comparator, it adds IEEE-754 NaN and signed-zero handling, RISC-V FEQ/FLT/FLE/FMIN/FMAX semantics, configurable format widths and backpressure. It sits between the FPU operand latch and the FPU result mux.

---
 rtl/fpu_pkg.sv | 40 ++++
 rtl/fp_classify.sv | 27 ++
 rtl/fp_compare_pipe.sv | 186 ++++++++++++++++++
 tb/tb_fp_compare_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU compare definitions: op encodings, relation codes, class record.
// Also provides the canonical quiet NaN pattern for any exponent/mantissa split.
// Pure declarations; no logic, no timing.
package fpu_pkg;

  // Compare unit operation encodings (5..7 all behave as relation-only CMP)
  localparam logic [2:0] FCMP_EQ  = 3'd0;
  localparam logic [2:0] FCMP_LT  = 3'd1;
  localparam logic [2:0] FCMP_LE  = 3'd2;
  localparam logic [2:0] FCMP_MIN = 3'd3;
  localparam logic [2:0] FCMP_MAX = 3'd4;
  localparam logic [2:0] FCMP_CMP = 3'd5;

  // Relation codes reported on rel
  localparam logic [1:0] REL_EQ = 2'b00;
  localparam logic [1:0] REL_GT = 2'b01;
  localparam logic [1:0] REL_LT = 2'b10;
  localparam logic [1:0] REL_UN = 2'b11;

  // Per-operand classification carried from S1 to S2
  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_zero;
    logic sign;
  } fp_class_t;

  // Canonical NaN {0, all-ones exponent, fraction MSB set, rest zero}.
  // Returned in a 64-bit container; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) begin
      r[man_w + i] = 1'b1;
    end
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Classifies one IEEE-754 operand: NaN, signaling NaN, zero, sign.
// Latency: combinational.
// Backpressure: none (pure function of the operand).
module fp_classify #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x_i,
  output logic                 is_nan_o,
  output logic                 is_snan_o,
  output logic                 is_zero_o,
  output logic                 sign_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = x_i[EXP_W+MAN_W-1:MAN_W];
  assign man_f = x_i[MAN_W-1:0];

  assign is_nan_o  = (&exp_f) && (|man_f);
  // Signaling NaNs have the quiet bit (fraction MSB) clear
  assign is_snan_o = is_nan_o && !man_f[MAN_W-1];
  assign is_zero_o = !(|exp_f) && !(|man_f);
  assign sign_o    = x_i[EXP_W+MAN_W];

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage IEEE-754 compare: relation, EQ/LT/LE predicate, MIN/MAX, invalid flag.
// Latency: S1 captures on accept, S2 registers one edge later; 1 pair/cycle.
// Backpressure: S2 holds when out_ready=0; in_ready = !s1_valid || s2_load.
module fp_compare_pipe
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int TAG_W = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       rel,
  output logic             flag,
  output logic [W-1:0]     sel,
  output logic             invalid,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [63:0]  CANON_FULL = canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0] CANON      = CANON_FULL[W-1:0];

  // ---------------- S1: classify + magnitude compare ----------------
  fp_class_t        ca, cb;
  logic             mag_gt_d, mag_eq_d;

  logic             s1_valid_q;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  fp_class_t        s1_ca_q, s1_cb_q;
  logic             s1_mag_gt_q, s1_mag_eq_q;

  logic             s2_load;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x_i       (a),
    .is_nan_o  (ca.is_nan),
    .is_snan_o (ca.is_snan),
    .is_zero_o (ca.is_zero),
    .sign_o    (ca.sign)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x_i       (b),
    .is_nan_o  (cb.is_nan),
    .is_snan_o (cb.is_snan),
    .is_zero_o (cb.is_zero),
    .sign_o    (cb.sign)
  );

  // Unsigned compare of {exp,man} orders magnitudes for finite values
  assign mag_gt_d = a[W-2:0] >  b[W-2:0];
  assign mag_eq_d = a[W-2:0] == b[W-2:0];

  // S2 takes a new entry when empty or being drained; S1 follows it
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid_q || s2_load;

  // S1 register: load a new pair whenever S1 can move forward
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s1_tag_q    <= '0;
      s1_ca_q     <= '0;
      s1_cb_q     <= '0;
      s1_mag_gt_q <= 1'b0;
      s1_mag_eq_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q      <= a;
        s1_b_q      <= b;
        s1_op_q     <= op;
        s1_tag_q    <= in_tag;
        s1_ca_q     <= ca;
        s1_cb_q     <= cb;
        s1_mag_gt_q <= mag_gt_d;
        s1_mag_eq_q <= mag_eq_d;
      end
    end
  end

  // ---------------- S2: relation and per-op results ----------------
  logic [1:0]   rel_d;
  logic         flag_d;
  logic [W-1:0] sel_d;
  logic         inv_d;
  logic         nan_any, snan_any, both_zero, a_lt, a_gt;

  assign nan_any   = s1_ca_q.is_nan  | s1_cb_q.is_nan;
  assign snan_any  = s1_ca_q.is_snan | s1_cb_q.is_snan;
  assign both_zero = s1_ca_q.is_zero & s1_cb_q.is_zero;

  // Ordered relation, then MIN/MAX ordering where -0 sorts below +0
  always_comb begin
    rel_d = REL_EQ;
    if (nan_any) begin
      rel_d = REL_UN;
    end else if (both_zero) begin
      rel_d = REL_EQ;
    end else if (s1_ca_q.sign != s1_cb_q.sign) begin
      rel_d = s1_ca_q.sign ? REL_LT : REL_GT;
    end else if (s1_mag_eq_q) begin
      rel_d = REL_EQ;
    end else if (s1_mag_gt_q ^ s1_ca_q.sign) begin
      rel_d = REL_GT;
    end else begin
      rel_d = REL_LT;
    end
    a_lt = both_zero ? (s1_ca_q.sign & ~s1_cb_q.sign) : (rel_d == REL_LT);
    a_gt = both_zero ? (~s1_ca_q.sign & s1_cb_q.sign) : (rel_d == REL_GT);
  end

  // Predicate, selection and invalid flag per operation
  always_comb begin
    flag_d = 1'b0;
    sel_d  = '0;
    inv_d  = 1'b0;
    case (s1_op_q)
      FCMP_EQ: begin
        flag_d = (rel_d == REL_EQ);
        inv_d  = snan_any;
      end
      FCMP_LT: begin
        flag_d = (rel_d == REL_LT);
        inv_d  = nan_any;
      end
      FCMP_LE: begin
        flag_d = (rel_d == REL_LT) || (rel_d == REL_EQ);
        inv_d  = nan_any;
      end
      FCMP_MIN, FCMP_MAX: begin
        if (s1_ca_q.is_nan && s1_cb_q.is_nan) begin
          sel_d = CANON;
        end else if (s1_ca_q.is_nan) begin
          sel_d = s1_b_q;
        end else if (s1_cb_q.is_nan) begin
          sel_d = s1_a_q;
        end else if (s1_op_q == FCMP_MIN) begin
          sel_d = a_lt ? s1_a_q : s1_b_q;
        end else begin
          sel_d = a_gt ? s1_a_q : s1_b_q;
        end
        inv_d = snan_any;
      end
      default: begin
        flag_d = 1'b0;
      end
    endcase
  end

  // S2 register: outputs come straight from these flops and hold while stalled
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid <= 1'b0;
      rel       <= '0;
      flag      <= 1'b0;
      sel       <= '0;
      invalid   <= 1'b0;
      out_tag   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        rel     <= rel_d;
        flag    <= flag_d;
        sel     <= sel_d;
        invalid <= inv_d;
        out_tag <= s1_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed bench for fp_compare_pipe (single and half precision instances).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_fp_compare_pipe;

  logic        CLK;
  logic        RESET_N;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sel;
  logic [2:0]  op;
  logic [3:0]  in_tag, out_tag;
  logic [1:0]  rel;
  logic        flag, invalid;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_sel;
  logic [2:0]  h_op;
  logic [3:0]  h_in_tag, h_out_tag;
  logic [1:0]  h_rel;
  logic        h_flag, h_invalid;

  int total = 0;
  int bad   = 0;

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .rel(rel), .flag(flag), .sel(sel), .invalid(invalid), .out_tag(out_tag)
  );

  fp_compare_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .CLK(CLK), .RESET_N(RESET_N),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .op(h_op), .in_tag(h_in_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .rel(h_rel), .flag(h_flag), .sel(h_sel), .invalid(h_invalid), .out_tag(h_out_tag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One isolated pair with out_ready=1: accept, check no early result, check result.
  task automatic run1(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic [2:0] top, input logic [3:0] ttag,
                      input logic [1:0] erel, input logic eflag,
                      input logic [31:0] esel, input logic einv);
    in_valid = 1'b1; a = ta; b = tb_; op = top; in_tag = ttag;
    #1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk({name, "_early"}, 32'(out_valid), 32'd0);
    step();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_rel"},   32'(rel),       32'(erel));
    chk({name, "_flag"},  32'(flag),      32'(eflag));
    chk({name, "_sel"},   sel,            esel);
    chk({name, "_inv"},   32'(invalid),   32'(einv));
    chk({name, "_tag"},   32'(out_tag),   32'(ttag));
  endtask

  function automatic logic [31:0] bpv(input int t);
    return 32'h4000_0000 | 32'(t);
  endfunction

  int next_tag, exp_tag, n_recv;
  logic acc;

  initial begin
    RESET_N = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; in_tag = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_op = '0; h_in_tag = '0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_rel",       32'(rel),       32'd0);
    chk("rst_sel",       sel,            32'd0);
    chk("rst_tag",       32'(out_tag),   32'd0);
    RESET_N = 1'b1;
    step();

    // Back-to-back ordered pairs
    in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h4000_0000; op = 3'd1; in_tag = 4'd1;
    step();
    a = 32'hC000_0000; b = 32'hBF80_0000; op = 3'd5; in_tag = 4'd2;
    #1;
    chk("b2b_early", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("b2b1_valid", 32'(out_valid), 32'd1);
    chk("b2b1_rel",   32'(rel),       32'd2);
    chk("b2b1_flag",  32'(flag),      32'd1);
    chk("b2b1_inv",   32'(invalid),   32'd0);
    chk("b2b1_tag",   32'(out_tag),   32'd1);
    step();
    chk("b2b2_valid", 32'(out_valid), 32'd1);
    chk("b2b2_rel",   32'(rel),       32'd2);
    chk("b2b2_flag",  32'(flag),      32'd0);
    chk("b2b2_sel",   sel,            32'd0);
    chk("b2b2_tag",   32'(out_tag),   32'd2);
    step();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Signed zero
    run1("z_eq",  32'h8000_0000, 32'h0000_0000, 3'd0, 4'd3, 2'b00, 1'b1, 32'h0000_0000, 1'b0);
    run1("z_min", 32'h8000_0000, 32'h0000_0000, 3'd3, 4'd4, 2'b00, 1'b0, 32'h8000_0000, 1'b0);
    run1("z_max", 32'h8000_0000, 32'h0000_0000, 3'd4, 4'd5, 2'b00, 1'b0, 32'h0000_0000, 1'b0);

    // NaN handling
    run1("q_eq",  32'h7FC0_0000, 32'h3F80_0000, 3'd0, 4'd6, 2'b11, 1'b0, 32'h0000_0000, 1'b0);
    run1("q_le",  32'h7FC0_0000, 32'h3F80_0000, 3'd2, 4'd7, 2'b11, 1'b0, 32'h0000_0000, 1'b1);
    run1("q_max", 32'h7FC0_0000, 32'h3F80_0000, 3'd4, 4'd8, 2'b11, 1'b0, 32'h3F80_0000, 1'b0);
    run1("s_min", 32'h7F80_0001, 32'h7FC0_0000, 3'd3, 4'd9, 2'b11, 1'b0, 32'h7FC0_0000, 1'b1);
    run1("s_eq",  32'h7F80_0001, 32'h3F80_0000, 3'd0, 4'd10, 2'b11, 1'b0, 32'h0000_0000, 1'b1);
    // Negative magnitudes: -3 vs -2 -> a<b
    run1("n_max", 32'hC040_0000, 32'hC000_0000, 3'd4, 4'd11, 2'b10, 1'b0, 32'hC000_0000, 1'b0);
    step();

    // Backpressure: out_ready=0, in_valid held for 5 cycles; only 2 accepts fit
    next_tag = 1;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1; a = bpv(next_tag); b = 32'h0; op = 3'd4; in_tag = 4'(next_tag);
      #1;
      if (cyc >= 2) begin
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_valid",    32'(out_valid), 32'd1);
        chk("bp_tag",      32'(out_tag),   32'd1);
        chk("bp_sel",      sel,            bpv(1));
        chk("bp_rel",      32'(rel),       32'd1);
      end
      acc = in_valid && in_ready;
      step();
      if (acc) next_tag++;
    end
    chk("bp_accepts", 32'(next_tag - 1), 32'd2);

    // Release: remaining tags 3..5 flow in, all 5 results must come out in order
    exp_tag = 1; n_recv = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (n_recv < 5) begin
        in_valid = (next_tag <= 5);
        a = bpv(next_tag); b = 32'h0; op = 3'd4; in_tag = 4'(next_tag);
        #1;
        if (out_valid) begin
          chk("rel_order_tag", 32'(out_tag), 32'(exp_tag));
          chk("rel_order_sel", sel,          bpv(exp_tag));
          exp_tag++;
          n_recv++;
        end
        acc = in_valid && in_ready;
        step();
        if (acc) next_tag++;
      end
    end
    in_valid = 1'b0;
    chk("rel_count", 32'(n_recv), 32'd5);
    #1;
    chk("rel_no_dup", 32'(out_valid), 32'd0);
    step();

    // Reset with two pairs in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h4000_0000; op = 3'd1; in_tag = 4'd9;
    step();
    a = 32'h4000_0000; b = 32'h3F80_0000; op = 3'd4; in_tag = 4'd10;
    step();
    in_valid = 1'b0;
    chk("rs_full_valid", 32'(out_valid), 32'd1);
    chk("rs_full_ready", 32'(in_ready),  32'd0);
    RESET_N = 1'b0;
    #1;
    chk("rs_valid",   32'(out_valid), 32'd0);
    chk("rs_rel",     32'(rel),       32'd0);
    chk("rs_flag",    32'(flag),      32'd0);
    chk("rs_sel",     sel,            32'd0);
    chk("rs_tag",     32'(out_tag),   32'd0);
    step();
    RESET_N = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("rs_no_stale", 32'(out_valid), 32'd0);
    run1("rs_new", 32'h4040_0000, 32'h4040_0000, 3'd2, 4'd11, 2'b00, 1'b1, 32'h0000_0000, 1'b0);
    step();
    chk("rs_drained", 32'(out_valid), 32'd0);

    // Half precision: 1.0 vs -1.0, MAX
    h_in_valid = 1'b1; h_a = 16'h3C00; h_b = 16'hBC00; h_op = 3'd4; h_in_tag = 4'd7;
    step();
    h_in_valid = 1'b0;
    step();
    chk("h_valid", 32'(h_out_valid), 32'd1);
    chk("h_sel",   32'(h_sel),       32'h3C00);
    chk("h_rel",   32'(h_rel),       32'd1);
    chk("h_flag",  32'(h_flag),      32'd0);
    chk("h_inv",   32'(h_invalid),   32'd0);
    chk("h_tag",   32'(h_out_tag),   32'd7);
    chk("h_ready", 32'(h_in_ready),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
